// File: rtl/even_parity_pkg.sv
// Shared definitions for the even-parity link (transmit generator and receive checker).
//   state_t          : receive FSM states
//   DEFAULT_DATA_W   : default number of data bits per frame
//   even_parity()    : XOR reduction of a vector; 0 means the vector holds an even number of ones
package even_parity_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int DEFAULT_DATA_W = 8;
   localparam int PARITY_VEC_W   = 64;

   // Narrower vectors are passed zero-extended; extra zeros do not change the result.
   function automatic logic even_parity(input logic [PARITY_VEC_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/even_parity_frame_checker_sat_counter.sv
// Saturating up-counter.
//   clk   : system clock
//   clear : synchronous clear, highest priority
//   inc   : count up by one unless already at all-ones
//   count : current value
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/even_parity_frame_checker.sv
// Even-parity frame receiver: deserialises DATA_W data bits (LSB first) plus one
// parity bit, flags frames whose total ones-count is odd, and counts bad frames.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   bit_in      : serial data/parity bit
//   bit_valid   : bit_in is valid this cycle
//   sof         : start of frame, qualified by bit_valid, marks data bit 0
//   data_out    : last completed data word, held until the next completed frame
//   out_valid   : one-cycle pulse, data_out/parity_err valid
//   parity_err  : frame failed even parity
//   frame_abort : one-cycle pulse, a partial frame was discarded by a new sof
//   err_cnt     : saturating count of frames with parity_err
//
// state  | meaning
// IDLE   | waiting for sof; non-sof bits are ignored
// DATA   | collecting data bits 1..DATA_W-1
// PARITY | waiting for the parity bit
module even_parity_frame_checker
   import even_parity_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              sof,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              parity_err,
   output logic              frame_abort,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int                IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t             state;
   logic [IDX_W-1:0]   cnt;
   logic [DATA_W-1:0]  shreg;
   logic               xr;
   logic               bad_frame;

   // Asserted exactly when the parity bit of a failing frame is being accepted,
   // so the counter steps on the same edge that raises out_valid/parity_err.
   assign bad_frame = bit_valid & ~sof & (state == PARITY) & (xr ^ bit_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         shreg       <= '0;
         xr          <= 1'b0;
         data_out    <= '0;
         out_valid   <= 1'b0;
         parity_err  <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         out_valid   <= 1'b0;
         frame_abort <= 1'b0;
         if (bit_valid) begin
            if (sof) begin
               // A sof always starts a fresh frame; any partial frame is dropped.
               if (state != IDLE) begin
                  frame_abort <= 1'b1;
               end
               shreg <= {{(DATA_W-1){1'b0}}, bit_in};
               xr    <= bit_in;
               cnt   <= IDX_W'(1);
               state <= (LAST_IDX == '0) ? PARITY : DATA;
            end else begin
               case (state)
                  DATA: begin
                     shreg[cnt] <= bit_in;
                     xr         <= xr ^ bit_in;
                     if (cnt == LAST_IDX) begin
                        cnt   <= '0;
                        state <= PARITY;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  PARITY: begin
                     parity_err <= xr ^ bit_in;
                     out_valid  <= 1'b1;
                     data_out   <= shreg;
                     cnt        <= '0;
                     state      <= IDLE;
                  end
                  default: begin
                     state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (bad_frame),
      .count (err_cnt)
   );

endmodule

// File: tb/tb_even_parity_frame_checker.sv
module tb_even_parity_frame_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       sof = 1'b0;

   logic [7:0] data_out;
   logic       out_valid;
   logic       parity_err;
   logic       frame_abort;
   logic [7:0] err_cnt;

   logic [7:0] data_out2;
   logic       out_valid2;
   logic       parity_err2;
   logic       frame_abort2;
   logic [1:0] err_cnt2;

   int n_assert = 0;
   int n_fail   = 0;
   int ov_count = 0;
   int ab_count = 0;

   logic       pend = 1'b0;
   logic [7:0] exp_d;
   logic       exp_p;
   int         exp_ec8;
   int         exp_ec2;
   int         ov_base;
   int         ab_base;

   even_parity_frame_checker #(.DATA_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .data_out(data_out), .out_valid(out_valid), .parity_err(parity_err),
      .frame_abort(frame_abort), .err_cnt(err_cnt)
   );

   even_parity_frame_checker #(.DATA_W(8), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
      .data_out(data_out2), .out_valid(out_valid2), .parity_err(parity_err2),
      .frame_abort(frame_abort2), .err_cnt(err_cnt2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (out_valid === 1'b1) ov_count++;
      if (frame_abort === 1'b1) ab_count++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One cycle: check a pending frame result, then drive this cycle's inputs.
   task automatic step(input logic v, input logic b, input logic s);
      @(negedge clk);
      if (pend) begin
         pend = 1'b0;
         chk("out_valid_pulse", 32'(out_valid), 32'd1);
         chk("data_out", 32'(data_out), 32'(exp_d));
         chk("parity_err", 32'(parity_err), 32'(exp_p));
         chk("err_cnt8", 32'(err_cnt), 32'(exp_ec8));
         chk("err_cnt2", 32'(err_cnt2), 32'(exp_ec2));
      end
      bit_valid = v;
      bit_in    = b;
      sof       = s;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input int maxgap,
                             input logic [7:0] ed, input logic ep, input int e8, input int e2);
      for (int i = 0; i <= 8; i++) begin
         int g;
         g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         repeat (g) step(1'b0, 1'b0, 1'b0);
         step(1'b1, (i < 8) ? d[i] : p, (i == 0));
      end
      pend    = 1'b1;
      exp_d   = ed;
      exp_p   = ep;
      exp_ec8 = e8;
      exp_ec2 = e2;
   endtask

   task automatic flush();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_parity_err", 32'(parity_err), 32'h0);
      chk("rst_frame_abort", 32'(frame_abort), 32'h0);
      chk("rst_err_cnt", 32'(err_cnt), 32'h0);
      rst = 1'b0;

      // Plain frames, back-to-back
      ov_base = ov_count;
      send_frame(8'h00, 1'b0, 0, 8'h00, 1'b0, 0, 0);
      send_frame(8'h01, 1'b1, 0, 8'h01, 1'b0, 0, 0);
      send_frame(8'h03, 1'b0, 0, 8'h03, 1'b0, 0, 0);
      send_frame(8'h80, 1'b1, 0, 8'h80, 1'b0, 0, 0);
      send_frame(8'h55, 1'b0, 0, 8'h55, 1'b0, 0, 0);
      send_frame(8'hAA, 1'b0, 0, 8'hAA, 1'b0, 0, 0);
      flush();
      chk("b2b_pulse_count", 32'(ov_count - ov_base), 32'd6);
      chk("out_valid_low_after", 32'(out_valid), 32'd0);

      // Non-sof bits in IDLE are ignored
      ov_base = ov_count;
      step(1'b1, 1'b1, 1'b0);
      repeat (10) step(1'b1, 1'b0, 1'b0);
      flush();
      chk("idle_ignore_pulses", 32'(ov_count - ov_base), 32'd0);
      chk("idle_data_hold", 32'(data_out), 32'hAA);

      // Parity error, then same data with correct parity
      send_frame(8'hDF, 1'b0, 0, 8'hDF, 1'b1, 1, 1);
      send_frame(8'hDF, 1'b1, 0, 8'hDF, 1'b0, 1, 1);
      flush();

      // Gaps between bits
      ov_base = ov_count;
      send_frame(8'h5A, 1'b0, 3, 8'h5A, 1'b0, 1, 1);
      flush();
      repeat (5) step(1'b0, 1'b0, 1'b0);
      chk("gap_pulse_count", 32'(ov_count - ov_base), 32'd1);
      chk("gap_data_hold", 32'(data_out), 32'h5A);

      // Abort from DATA: 4 data bits then a new sof
      ov_base = ov_count;
      ab_base = ab_count;
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 0, 8'h3C, 1'b0, 1, 1);
      flush();
      chk("abort_data_count", 32'(ab_count - ab_base), 32'd1);
      chk("abort_data_ov", 32'(ov_count - ov_base), 32'd1);

      // Abort from PARITY: 8 data bits then a new sof instead of parity
      ov_base = ov_count;
      ab_base = ab_count;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, (i == 0));
      send_frame(8'h66, 1'b0, 0, 8'h66, 1'b0, 1, 1);
      flush();
      chk("abort_par_count", 32'(ab_count - ab_base), 32'd1);
      chk("abort_par_ov", 32'(ov_count - ov_base), 32'd1);

      // Reset mid-frame after 5 bits
      ov_base = ov_count;
      ab_base = ab_count;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, (i == 0));
      @(negedge clk);
      rst = 1'b1;
      sof = 1'b1;
      @(negedge clk);
      sof = 1'b0;
      @(negedge clk);
      chk("midrst_data_out", 32'(data_out), 32'h0);
      chk("midrst_out_valid", 32'(out_valid), 32'h0);
      chk("midrst_parity_err", 32'(parity_err), 32'h0);
      chk("midrst_err_cnt", 32'(err_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bit_valid = 1'b0;
      // Leftover data bits after reset must not complete a frame
      repeat (4) step(1'b1, 1'b1, 1'b0);
      flush();
      chk("midrst_no_pulse", 32'(ov_count - ov_base), 32'd0);
      chk("midrst_no_abort", 32'(ab_count - ab_base), 32'd0);
      send_frame(8'h0F, 1'b0, 0, 8'h0F, 1'b0, 0, 0);
      flush();

      // Saturation: five bad frames (0x01 with parity 0)
      send_frame(8'h01, 1'b0, 0, 8'h01, 1'b1, 1, 1);
      send_frame(8'h01, 1'b0, 0, 8'h01, 1'b1, 2, 2);
      send_frame(8'h01, 1'b0, 0, 8'h01, 1'b1, 3, 3);
      send_frame(8'h01, 1'b0, 0, 8'h01, 1'b1, 4, 3);
      send_frame(8'h01, 1'b0, 1, 8'h01, 1'b1, 5, 3);
      flush();
      chk("sat_err_cnt2", 32'(err_cnt2), 32'd3);
      chk("sat_err_cnt8", 32'(err_cnt), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/even_parity_frame_checker.md
Name: even_parity_frame_checker

Overview:
- Receiving end of the even-parity link: deserialises DATA_W data bits plus one even-parity bit, then checks parity over the whole frame.
- Presents the recovered byte with a one-cycle valid strobe and a parity-error flag, and keeps a saturating error count.
- Sits between the serial link and the byte consumer, opposite the even parity generator on the transmit side.

Parameters:
- DATA_W, 8, data bits per frame (>=2).
- CNT_W, 8, width of the saturating parity-error counter (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data/parity bit.
- bit_valid  input  1  bit_in is valid this cycle; gaps allowed between bits.
- sof  input  1  start of frame; qualified by bit_valid, marks data bit 0.
- data_out  output  DATA_W  recovered data word, LSB = first received bit.
- out_valid  output  1  one-cycle pulse: data_out and parity_err are valid.
- parity_err  output  1  1 when ones-count over data+parity is odd; valid with out_valid.
- frame_abort  output  1  one-cycle pulse: frame in progress was discarded.
- err_cnt  output  CNT_W  saturating count of frames with parity_err=1.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all outputs 0, FSM to IDLE, bit counter 0, shift register 0, running XOR 0. rst overrides all other inputs in the same cycle. A frame in progress is dropped with no out_valid and no frame_abort.
- Frame format: DATA_W data bits, LSB first, then 1 parity bit. Correct frame: XOR of all DATA_W+1 bits = 0.
- FSM states:
  - IDLE: bit_valid&sof -> store bit 0, xor=bit_in, cnt=1 -> DATA. bit_valid without sof -> ignored, stay IDLE.
  - DATA: bit_valid&!sof -> store bit at index cnt, xor^=bit_in, cnt++. When the bit at index DATA_W-1 is stored -> PARITY.
  - PARITY: bit_valid&!sof -> parity_err<=xor^bit_in, out_valid<=1, data_out<=shift reg -> IDLE.
- Abort: bit_valid&sof in DATA or PARITY -> frame_abort pulses next cycle and the partial frame is discarded. The same bit starts a new frame (bit 0, cnt=1, state DATA). No out_valid for the aborted frame.
- Timing:
  - out_valid/parity_err/data_out update on the edge that accepts the parity bit, so they are visible the cycle after it. Latency is 1 cycle from parity bit to out_valid.
  - data_out holds its value until the next completed frame. out_valid is high for exactly 1 cycle.
  - Back-to-back frames: sof in the cycle after the parity bit is accepted normally (FSM is already IDLE).
- err_cnt: increments in the same cycle out_valid&parity_err is registered. It saturates at 2^CNT_W-1 and clears only on rst.
- bit_valid=0: no state change in any state; gaps of any length are tolerated.

Decomposition:
- Shared package even_parity_pkg:
  - state enum (IDLE, DATA, PARITY);
  - default DATA_W constant;
  - function even_parity(vector) returning the XOR reduction, also used by the generator.
- Sub-module sat_counter (width param, inc, clear on rst) for err_cnt.
- Everything else stays in a single module.

Test Plan:
- Reset then frame 0x00, parity 0 -> out_valid pulse, data_out=0x00, parity_err=0, err_cnt=0.
- Frames 0x01/p1, 0x03/p0, 0x80/p1, 0x55/p0, 0xAA/p0, sent back-to-back -> five pulses, correct data, parity_err=0 each.
- Frame 0xDF with parity 0 (7 ones) -> data_out=0xDF, parity_err=1, err_cnt=1. Then 0xDF with parity 1 -> parity_err=0, err_cnt stays 1.
- Frame 0x5A/p0 with random 0-3 cycle bit_valid gaps -> data_out=0x5A, parity_err=0, out_valid exactly 1 cycle after the parity bit.
- sof reasserted after 4 data bits, then full frame 0x3C/p0 -> frame_abort one pulse, single out_valid with 0x3C, parity_err=0.
- rst mid-frame after 5 bits, then frame 0x0F/p0 -> no pulse from the partial frame, outputs 0 during reset, then data_out=0x0F. With CNT_W=2, 5 bad frames -> err_cnt saturates at 3.
